// File: rtl/nav_ctrl.sv
// Navigation sequencer feeding the heading PID: in-place turns and forward moves with a trapezoidal speed ramp.
// Optional heading watchdog is enabled by defining NAV_HDNG_TIMEOUT_EN.
module nav_ctrl #(
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [5:0]  ACC_INC   = 6'h18,
  parameter logic [6:0]  DEC_INC   = 7'h30,
  parameter logic [7:0]  FAST_DEC  = 8'h60
`ifdef NAV_HDNG_TIMEOUT_EN
  ,
  parameter int unsigned TO_W      = 20
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        en_fusion,
  output logic        mv_cmplt,
  output logic        hdng_to
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDNG    = 2'd1,
    RAMP_UP = 2'd2,
    DECEL   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic [7:0]  step_q, step_d;
  logic        moving_q, moving_d;
  logic        cmplt_q, cmplt_d;
  logic        lft_q, lft_d;
  logic        rght_q, rght_d;
  logic        lft_rise_s;
  logic        rght_rise_s;

  // 12-bit add clamped to the speed ceiling
  function automatic logic [10:0] sat_add(input logic [10:0] spd, input logic [5:0] inc);
    logic [11:0] sum;
    sum = {1'b0, spd} + {6'b000000, inc};
    if (sum > {1'b0, MAX_FRWRD}) begin
      sat_add = MAX_FRWRD;
    end else begin
      sat_add = sum[10:0];
    end
  endfunction

  // 12-bit subtract clamped to zero
  function automatic logic [10:0] sat_sub(input logic [10:0] spd, input logic [7:0] dec);
    logic [11:0] diff;
    if ({1'b0, spd} < {4'b0000, dec}) begin
      sat_sub = 11'h000;
    end else begin
      diff    = {1'b0, spd} - {4'b0000, dec};
      sat_sub = diff[10:0];
    end
  endfunction

  assign lft_rise_s  = lft_opn & ~lft_q;
  assign rght_rise_s = rght_opn & ~rght_q;

`ifdef NAV_HDNG_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            hdng_to_q, hdng_to_d;
`endif

  // Next-state, speed profile and completion logic
  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    step_d  = step_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    cmplt_d = 1'b0;
`ifdef NAV_HDNG_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    hdng_to_d = hdng_to_q;
`endif
    case (state_q)
      IDLE: begin
        spd_d = 11'h000;
        if (strt_hdng) begin
          state_d = HDNG;
`ifdef NAV_HDNG_TIMEOUT_EN
          to_cnt_d  = '0;
          hdng_to_d = 1'b0;
`endif
        end else if (strt_mv) begin
          lft_d  = lft_opn;
          rght_d = rght_opn;
          // Blocked at start: skip the ramp and finish from zero speed
          if (!frwrd_opn) begin
            state_d = DECEL;
            step_d  = FAST_DEC;
          end else begin
            state_d = RAMP_UP;
            step_d  = {1'b0, DEC_INC};
          end
        end else begin
          state_d = IDLE;
        end
      end
      HDNG: begin
        spd_d = 11'h000;
        if (at_hdng) begin
          state_d = IDLE;
          cmplt_d = 1'b1;
        end
`ifdef NAV_HDNG_TIMEOUT_EN
        else if (to_cnt_q == {TO_W{1'b1}}) begin
          state_d   = IDLE;
          cmplt_d   = 1'b1;
          hdng_to_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_d = HDNG;
        end
`endif
      end
      RAMP_UP: begin
        lft_d  = lft_opn;
        rght_d = rght_opn;
        if (!frwrd_opn) begin
          state_d = DECEL;
          step_d  = FAST_DEC;
        end else if (stp_lft && lft_rise_s) begin
          state_d = DECEL;
          step_d  = {1'b0, DEC_INC};
        end else if (stp_rght && rght_rise_s) begin
          state_d = DECEL;
          step_d  = {1'b0, DEC_INC};
        end else if (hdng_vld) begin
          spd_d = sat_add(spd_q, ACC_INC);
        end else begin
          spd_d = spd_q;
        end
      end
      DECEL: begin
        // Step only ever upgrades to the emergency rate
        if (!frwrd_opn) begin
          step_d = FAST_DEC;
        end else begin
          step_d = step_q;
        end
        if (spd_q == 11'h000) begin
          state_d = IDLE;
          cmplt_d = 1'b1;
        end else if (hdng_vld) begin
          spd_d = sat_sub(spd_q, step_q);
        end else begin
          spd_d = spd_q;
        end
      end
      default: begin
        state_d = IDLE;
        spd_d   = 11'h000;
      end
    endcase
    moving_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      spd_q    <= 11'h000;
      step_q   <= 8'h00;
      moving_q <= 1'b0;
      cmplt_q  <= 1'b0;
      lft_q    <= 1'b0;
      rght_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      spd_q    <= spd_d;
      step_q   <= step_d;
      moving_q <= moving_d;
      cmplt_q  <= cmplt_d;
      lft_q    <= lft_d;
      rght_q   <= rght_d;
    end
  end

`ifdef NAV_HDNG_TIMEOUT_EN
  // Heading watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      hdng_to_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      hdng_to_q <= hdng_to_d;
    end
  end

  assign hdng_to = hdng_to_q;
`else
  assign hdng_to = 1'b0;
`endif

  assign moving    = moving_q;
  assign frwrd_spd = spd_q;
  assign mv_cmplt  = cmplt_q;
  assign en_fusion = (spd_q > (MAX_FRWRD >> 1));

endmodule
